// File: rtl/prism_pkg.sv
// Shared encodings for the SIT load controller: FSM states, SIT debug addresses,
// and the high-word mask helper.
package prism_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_LO,
    S_WR_LO,
    S_WAIT_HI,
    S_WR_HI,
    S_GAP,
    S_VFY_LO,
    S_VFY_HI,
    S_DONE
  } state_t;

  localparam logic [5:0] SIT_ADDR_LO = 6'h10;
  localparam logic [5:0] SIT_ADDR_HI = 6'h14;

  // Only the low (width-32) bits of the high word are real row bits.
  function automatic logic [31:0] hi_mask(input int width);
    logic [63:0] m;
    m = (64'd1 << (width - 32)) - 64'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/prism_sit_load_ctrl.sv
// Streams DEPTH SIT rows (two 32-bit words each) onto the SIT debug bus; the host owns
// the bus while idle. Define PRISM_SIT_VERIFY_EN to read back and check the last row.
module prism_sit_load_ctrl
  import prism_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic [5:0]  host_addr,
  input  logic        host_wr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic [5:0]  debug_addr,
  output logic        debug_wr,
  output logic [31:0] debug_wdata,
  input  logic [31:0] debug_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] HI_MASK = hi_mask(WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(DEPTH);

  state_t        state, state_nxt;
  logic [CW-1:0] row_cnt;
  logic [CW-1:0] row_inc;
  logic [31:0]   lo_q, hi_q;
  logic          xfer;
  logic          vfy_fail;

  assign xfer    = s_valid & s_ready;
  assign row_inc = row_cnt + 1'b1;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE) && !abort;

`ifndef PRISM_SIT_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^debug_rdata;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!abort) begin
        if (state == S_IDLE && start) row_cnt <= '0;
        if (state == S_GAP)           row_cnt <= row_inc;
        if (xfer && state == S_WAIT_LO) lo_q <= s_data;
        if (xfer && state == S_WAIT_HI) hi_q <= s_data & HI_MASK;
      end
      if (abort)                           err <= 1'b1;
      else if (state == S_IDLE && start)   err <= 1'b0;
      else if (vfy_fail)                   err <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    host_gnt    = 1'b0;
    debug_addr  = '0;
    debug_wr    = 1'b0;
    debug_wdata = '0;
    vfy_fail    = 1'b0;

    case (state)
      S_IDLE: begin
        host_gnt    = 1'b1;
        debug_addr  = host_addr;
        debug_wr    = host_wr;
        debug_wdata = host_wdata;
        if (start) state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = S_WR_LO;
      end
      S_WR_LO: begin
        debug_addr  = SIT_ADDR_LO;
        debug_wr    = 1'b1;
        debug_wdata = lo_q;
        state_nxt   = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = S_WR_HI;
      end
      S_WR_HI: begin
        debug_addr  = SIT_ADDR_HI;
        debug_wr    = 1'b1;
        debug_wdata = hi_q;
        state_nxt   = S_GAP;
      end
      S_GAP: begin
`ifdef PRISM_SIT_VERIFY_EN
        state_nxt = (row_inc == LAST) ? S_VFY_LO : S_WAIT_LO;
`else
        state_nxt = (row_inc == LAST) ? S_DONE : S_WAIT_LO;
`endif
      end
`ifdef PRISM_SIT_VERIFY_EN
      S_VFY_LO: begin
        debug_addr = SIT_ADDR_LO;
        vfy_fail   = (debug_rdata != lo_q);
        state_nxt  = S_VFY_HI;
      end
      S_VFY_HI: begin
        debug_addr = SIT_ADDR_HI;
        vfy_fail   = (debug_rdata != hi_q);
        state_nxt  = S_DONE;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_nxt = S_IDLE;
      debug_wr  = 1'b0;
      s_ready   = 1'b0;
    end
  end

endmodule

// File: tb/tb_prism_sit_load_ctrl.sv
// Self-checking bench for prism_sit_load_ctrl: directed and randomized load sequences
// compared against a row-list reference model, plus abort, host-arbitration and reset cases.
module tb_prism_sit_load_ctrl;

  localparam int DEPTH = 2;
  localparam int WIDTH = 48;
  localparam int NW    = 2 * DEPTH;
`ifdef PRISM_SIT_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  typedef logic [31:0] words_t [NW];

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic [5:0]  host_addr;
  logic        host_wr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [5:0]  debug_addr;
  logic        debug_wr;
  logic [31:0] debug_wdata;
  logic [31:0] debug_rdata;
  logic        busy, done, err;

  logic [31:0] sit_mem [64];
  logic        corrupt_lo;

  int n_checks = 0;
  int n_err    = 0;

  prism_sit_load_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .host_addr(host_addr), .host_wr(host_wr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .debug_addr(debug_addr), .debug_wr(debug_wr), .debug_wdata(debug_wdata),
    .debug_rdata(debug_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Simple SIT model: remembers writes, optionally returns a bad low word on readback.
  always @(posedge clk) if (debug_wr) sit_mem[debug_addr] <= debug_wdata;
  assign debug_rdata = (corrupt_lo && debug_addr == 6'h10) ? 32'h22222223 : sit_mem[debug_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: s_valid constant, 1: toggles every cycle, 2: random
  task automatic run_seq(input string name, input words_t w, input int mode, input bit corrupt);
    logic [5:0]  exp_a[$];
    logic [31:0] exp_d[$];
    logic [5:0]  obs_a[$];
    logic [31:0] obs_d[$];
    logic [63:0] h;
    int idx = 0, cyc = 0, dones = 0, viol = 0;
    bit prev = 0, fin = 0, xfer;

    for (int r = 0; r < DEPTH; r++) begin
      exp_a.push_back(6'h10); exp_d.push_back(w[2*r]);
      h = {32'd0, w[2*r+1]} % (64'd1 << (WIDTH - 32));
      exp_a.push_back(6'h14); exp_d.push_back(h[31:0]);
    end
    corrupt_lo = corrupt;
    pulse_start();
    while (!fin && cyc < 300) begin
      case (mode)
        0:       s_valid = (idx < NW);
        1:       s_valid = (idx < NW) && cyc[0];
        default: s_valid = (idx < NW) && ($urandom_range(0, 1) == 1);
      endcase
      s_data = (idx < NW) ? w[idx] : $urandom;
      @(negedge clk);
      if (debug_wr) begin
        obs_a.push_back(debug_addr); obs_d.push_back(debug_wdata);
        if (prev) viol++;
      end
      prev = debug_wr;
      if (done) begin dones++; fin = 1; end
      xfer = s_valid && s_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({name, "_finished"}, fin, 1);
    check({name, "_done_once"}, dones, 1);
    check({name, "_words_taken"}, idx, NW);
    check({name, "_write_count"}, obs_a.size(), NW);
    for (int i = 0; i < NW && i < obs_a.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), obs_a[i], exp_a[i]);
      check($sformatf("%s_data%0d", name, i), obs_d[i], exp_d[i]);
    end
    check({name, "_no_b2b_wr"}, viol, 0);
    check({name, "_err"}, err, VFY && corrupt);
    check({name, "_idle"}, busy, 0);
    check({name, "_gnt"}, host_gnt, 1);
    corrupt_lo = 1'b0;
  endtask

  initial begin
    words_t spec_w, rnd_w;
    int n;
    spec_w = '{32'h11111111, 32'h0000AAAA, 32'h22222222, 32'h0000BBBB};
    for (int i = 0; i < 64; i++) sit_mem[i] = '0;
    rst = 1'b1; start = 0; abort = 0; s_valid = 0; s_data = '0;
    host_addr = '0; host_wr = 0; host_wdata = '0; corrupt_lo = 0;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_debug_wr", debug_wr, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_gnt", host_gnt, 1);

    run_seq("spec_const", spec_w, 0, 0);
    run_seq("spec_toggle", spec_w, 1, 0);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NW; i++) rnd_w[i] = $urandom;
      run_seq($sformatf("rand%0d", t), rnd_w, 2, 0);
    end
    run_seq("spec_badread", spec_w, 0, 1);

    // start together with abort: stays idle and flags err
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_err", err, 1);

    // abort in WAIT_HI of row 0
    pulse_start();
    check("abort_start_clears_err", err, 0);
    s_valid = 1'b1; s_data = 32'hDEAD0001;
    n = 0;
    do begin @(negedge clk); n++; end while (!(debug_wr && debug_addr == 6'h10) && n < 20);
    check("abort_saw_wr_lo", debug_wr, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("abort_in_wait_hi", s_ready, 1);
    abort = 1'b1; #1;
    check("abort_debug_wr", debug_wr, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_gnt", host_gnt, 1);
    check("abort_err", err, 1);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || debug_wr) n++;
    end
    check("abort_quiet", n, 0);

    // host arbitration
    host_addr = 6'h10; host_wdata = 32'h5A5A1234; host_wr = 1'b1; #1;
    check("host_idle_wr", debug_wr, 1);
    check("host_idle_addr", debug_addr, 6'h10);
    check("host_idle_data", debug_wdata, 32'h5A5A1234);
    check("host_idle_gnt", host_gnt, 1);
    host_wr = 1'b0;
    pulse_start();
    host_wr = 1'b1;
    @(negedge clk);
    check("host_busy_wr", debug_wr, 0);
    check("host_busy_gnt", host_gnt, 0);
    check("host_busy_busy", busy, 1);
    host_wr = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;

    // reset mid-WR_LO
    pulse_start();
    s_valid = 1'b1; s_data = 32'hC0FFEE00;
    n = 0;
    do begin @(negedge clk); n++; end while (!(debug_wr && debug_addr == 6'h10) && n < 20);
    check("rst_mid_saw_wr_lo", debug_wr, 1);
    rst = 1'b1; #1;
    s_valid = 1'b0;
    check("rst_mid_debug_wr", debug_wr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_s_ready", s_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_gnt", host_gnt, 1);

    for (int i = 0; i < NW; i++) rnd_w[i] = $urandom;
    run_seq("after_rst", rnd_w, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/prism_sit_load_ctrl.md
PRISM_SIT_LOAD_CTRL -- requirements
Module: prism_sit_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of SIT rows loaded per sequence.
REQ-002 SHALL have parameter WIDTH, default 48, SIT row width in bits (33..64); each row is written as two 32-bit words.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a load sequence; ignored unless state is IDLE.
REQ-006 SHALL have port abort, input, 1, level; returns to IDLE next cycle from any state.
REQ-007 SHALL have port s_valid / s_ready / s_data, in/out/in, 1/1/32, row-word stream handshake; low word first, then high word, per row.
REQ-008 SHALL have port host_addr / host_wr / host_wdata / host_gnt, in/in/in/out, 6/1/32/1, host debug requester.
REQ-009 SHALL have port debug_addr / debug_wr / debug_wdata / debug_rdata, out/out/out/in, 6/1/32/32, debug bus to the SIT.
REQ-010 SHALL have port busy / done / err, out, 1 each; status.

Function
REQ-011 SHALL implement states IDLE, WAIT_LO, WR_LO, WAIT_HI, WR_HI, GAP, VFY_LO, VFY_HI, DONE.
REQ-012 SHALL in IDLE grant the host: host_gnt=1, debug_* equals host_* combinationally, s_ready=0.
REQ-013 SHALL on start in IDLE clear err, load row counter with 0, go to WAIT_LO; host_gnt=0 in every non-IDLE state and host_wr is dropped (never forwarded).
REQ-014 SHALL in WAIT_LO/WAIT_HI assert s_ready; a word transfers when s_valid and s_ready are both high; capture s_data and go to WR_LO/WR_HI.
REQ-015 SHALL in WR_LO drive debug_addr=6'h10, debug_wr=1, debug_wdata=low word for exactly one cycle, then WAIT_HI.
REQ-016 SHALL in WR_HI drive debug_addr=6'h14, debug_wr=1, debug_wdata=high word with bits [31:WIDTH-32] forced 0, for exactly one cycle, then GAP.
REQ-017 SHALL in GAP hold debug_wr=0 one cycle, increment row counter; if counter reaches DEPTH go to VFY_LO (or DONE if verify compiled out), else WAIT_LO.
REQ-018 SHALL retain the last row's low/high words for verification.
REQ-019 SHALL in VFY_LO drive debug_addr=6'h10, debug_wr=0, compare debug_rdata to retained low word; VFY_HI same at 6'h14 against masked high word; any mismatch sets err (sticky until next start).
REQ-020 SHALL in DONE pulse done=1 for one cycle then return to IDLE.
REQ-021 SHALL hold busy=1 in every state except IDLE.
REQ-022 SHALL treat start coincident with abort as abort (stay IDLE).
REQ-023 SHALL on abort discard partial row, set err=1, not pulse done, and drive debug_wr=0 that cycle.
REQ-024 SHALL size the row counter to clog2(DEPTH+1) bits; no wrap possible.

Reset
REQ-025 SHALL on rst asynchronously force IDLE, counter 0, captured words 0, err=0, done=0, busy=0, debug_wr=0, s_ready=0.
REQ-026 SHALL after rst release grant the host on the first clock (host_gnt=1).

Configuration
REQ-027 SHALL compile verification states VFY_LO/VFY_HI only when PRISM_SIT_VERIFY_EN is defined; without it GAP after the final row goes directly to DONE and err is set only by abort.

Structure
REQ-028 SHALL place state encoding and SIT debug address constants (6'h10, 6'h14) in shared package prism_pkg.
REQ-029 SHALL contain no sub-modules; a single FSM with a datapath register pair.

Verification
REQ-030 SHALL cover: DEPTH=2, start, stream 0x11111111,0x0000AAAA,0x22222222,0x0000BBBB with s_valid constant -> writes at 0x10/0x14 in order, done pulses once, err=0.
REQ-031 SHALL cover: s_valid toggling every other cycle -> no word lost or duplicated, write order unchanged, debug_wr never asserted two consecutive cycles.
REQ-032 SHALL cover: verify enabled, debug_rdata returns 0x22222223 in VFY_LO -> err=1 after DONE, done still pulses.
REQ-033 SHALL cover: abort asserted in WAIT_HI of row 0 -> IDLE next cycle, err=1, no done, host_gnt=1.
REQ-034 SHALL cover: host_wr=1 at 0x10 while busy -> debug_wr not driven by host, host_gnt=0; same write in IDLE -> forwarded same cycle.
REQ-035 SHALL cover: rst asserted mid-WR_LO -> debug_wr=0 immediately, all status 0, busy=0.
